baud_tick_gen: RTL
==================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter NCH, default 2: number of independent baud channels.
REQ-002 Parameter CNT_W, default 16: integer divisor and bit-counter width.
REQ-003 Parameter FRAC_W, default 4: fractional divisor width, in 1/2^FRAC_W cycle units.
REQ-004 Parameter DIV_RST, default 2083: integer divisor after reset; fractional divisor resets to 0.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 div_int  input  CNT_W  requested integer divisor, in clk cycles per bit.
REQ-008 div_frac  input  FRAC_W  requested fractional divisor.
REQ-009 div_load  input  1  single-cycle strobe; captures div_int/div_frac into the shadow register.
REQ-010 ch_en  input  NCH  per-channel count enable; level-sensitive, high while a frame is active.
REQ-011 mid_tick  output  NCH  one-cycle pulse at the mid-bit sample point.
REQ-012 bit_tick  output  NCH  one-cycle pulse on the last cycle of each bit period.
REQ-013 bps_level  output  NCH  high during the second half of each bit (count > half).
REQ-014 cfg_err  output  1  sticky flag: a rejected divisor load has occurred.

Function
REQ-015 The shadow divisor SHALL capture div_int/div_frac on the cycle after div_load when div_int >= 2.
REQ-016 If div_int < 2 at div_load, the shadow SHALL stay unchanged and cfg_err SHALL set; only the next accepted load or reset clears it.
REQ-017 Each channel SHALL hold an active divisor copied from the shadow when the channel is idle (ch_en=0) or on its bit_tick cycle; bits never change length mid-bit.
REQ-018 Channel state: count (CNT_W) and frac_acc (FRAC_W).
  - When ch_en=0, both SHALL be held at 0 synchronously and all channel outputs SHALL be 0.
REQ-019 The bit period length P SHALL be div_int, plus 1 when frac_acc + div_frac carries out of FRAC_W bits.
  - frac_acc SHALL update modulo 2^FRAC_W on each bit_tick.
REQ-020 count SHALL increment each enabled cycle and wrap from P-1 to 0; bit_tick SHALL be high exactly when count == P-1.
REQ-021 mid_tick SHALL be high exactly when count == (div_int >> 1), using the integer part only.
REQ-022 bps_level SHALL be high exactly when count > (div_int >> 1).
REQ-023 ch_en rising at cycle t: count is 0 at t+1, first mid_tick at t+1+(div_int>>1), first bit_tick at t+P.
REQ-024 ch_en falling mid-bit SHALL abort the bit immediately; no tick is emitted on or after the cycle ch_en is low.
REQ-025 div_load coinciding with a channel's bit_tick: the next bit SHALL use the old shadow value; the new value takes effect one bit later.
REQ-026 Channels are fully independent; one shared shadow, with per-channel active copies.

Reset
REQ-027 rstn low: shadow = DIV_RST/0; all counts, frac_acc, active divisors = 0/DIV_RST; mid_tick, bit_tick, bps_level, cfg_err = 0.
REQ-028 Reset asserted mid-bit SHALL abort all channels; after release, counting resumes only per REQ-023.

Structure
REQ-029 Package baud_pkg SHALL hold CNT_W/FRAC_W defaults, MIN_DIV=2, DIV_RST, and a per-channel state record type.
REQ-030 Sub-module baud_chan SHALL implement one channel, with REQ-017 to REQ-024 instantiated NCH times.
  - The shadow register and cfg_err SHALL live in the top level.

Verification
REQ-031 div_int=10, frac=0, ch_en[0]=1 -> bit_tick every 10 cycles, mid_tick 5 cycles after count 0, bps_level high for 4 of every 10 cycles.
REQ-032 div_int=10, div_frac=8 (FRAC_W=4) -> bit periods alternate 10,11,10,11; 20 bits total 210 cycles.
REQ-033 div_load of 20 at count 3 of a 10-cycle bit -> current bit ends at 10, next bits are 20 cycles; the other idle channel starts at 20.
REQ-034 div_load with div_int=1 -> cfg_err=1, periods unchanged; a later load of 8 -> cfg_err=0, periods 8.
REQ-035 ch_en[1] dropped at count 7 of 10 -> no bit_tick on channel 1, channel 0 unaffected; re-enable -> first bit_tick P cycles later.
REQ-036 rstn pulsed mid-bit on both channels -> all outputs 0 asynchronously; divisor returns to 2083.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants and the channel state record for the baud tick generator.
package baud_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;
  localparam int MIN_DIV    = 2;
  localparam int DIV_RST_DEF = 2083;

  // Record layout at the default widths; baud_chan rebuilds it at its own widths.
  typedef struct packed {
    logic                  run;
    logic [CNT_W_DEF-1:0]  cnt;
    logic [FRAC_W_DEF-1:0] acc;
    logic [CNT_W_DEF-1:0]  dint;
    logic [FRAC_W_DEF-1:0] dfrac;
  } chan_st_t;
endpackage

// File: rtl/baud_chan.sv
// One baud channel: bit counter, fractional accumulator and latched divisor.
module baud_chan import baud_pkg::*; #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [CNT_W-1:0]  sh_int,
  input  logic [FRAC_W-1:0] sh_frac,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              bps_level
);
  typedef struct packed {
    logic              run;
    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [CNT_W-1:0]  dint;
    logic [FRAC_W-1:0] dfrac;
  } st_t;

  st_t               st_q, st_d;
  logic [FRAC_W:0]   acc_sum;
  logic [CNT_W-1:0]  last_cnt, half_cnt;
  logic              live;

  always_comb begin
    acc_sum   = {1'b0, st_q.acc} + {1'b0, st_q.dfrac};
    last_cnt  = st_q.dint - CNT_W'(1) + CNT_W'(acc_sum[FRAC_W]);
    half_cnt  = st_q.dint >> 1;
    // First enabled cycle only arms the channel; count 0 is the cycle after.
    live      = en & st_q.run;
    bit_tick  = live && (st_q.cnt == last_cnt);
    mid_tick  = live && (st_q.cnt == half_cnt);
    bps_level = live && (st_q.cnt > half_cnt);

    st_d = st_q;
    if (!en) begin
      st_d.run = 1'b0;
      st_d.cnt = '0;
      st_d.acc = '0;
    end else if (!st_q.run) begin
      st_d.run = 1'b1;
    end else if (bit_tick) begin
      st_d.cnt = '0;
      st_d.acc = acc_sum[FRAC_W-1:0];
    end else begin
      st_d.cnt = st_q.cnt + CNT_W'(1);
    end
    // Divisor only follows the shadow between bits, never inside one.
    if (!en || !st_q.run || bit_tick) begin
      st_d.dint  = sh_int;
      st_d.dfrac = sh_frac;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st_q <= '{run: 1'b0, cnt: '0, acc: '0, dint: CNT_W'(DIV_RST), dfrac: '0};
    else       st_q <= st_d;
  end
endmodule

// File: rtl/baud_tick_gen.sv
// Multi-channel fractional baud tick generator with a shared, validated divisor shadow.
module baud_tick_gen import baud_pkg::*; #(
  parameter int NCH     = 2,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  input  logic [NCH-1:0]    ch_en,
  output logic [NCH-1:0]    mid_tick,
  output logic [NCH-1:0]    bit_tick,
  output logic [NCH-1:0]    bps_level,
  output logic              cfg_err
);
  logic [CNT_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              cfg_err_q, cfg_err_d;

  always_comb begin
    sh_int_d  = sh_int_q;
    sh_frac_d = sh_frac_q;
    cfg_err_d = cfg_err_q;
    if (div_load) begin
      if (div_int >= CNT_W'(MIN_DIV)) begin
        sh_int_d  = div_int;
        sh_frac_d = div_frac;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_int_q  <= CNT_W'(DIV_RST);
      sh_frac_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      sh_int_q  <= sh_int_d;
      sh_frac_q <= sh_frac_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    baud_chan #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .DIV_RST(DIV_RST)) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .en        (ch_en[c]),
      .sh_int    (sh_int_q),
      .sh_frac   (sh_frac_q),
      .mid_tick  (mid_tick[c]),
      .bit_tick  (bit_tick[c]),
      .bps_level (bps_level[c])
    );
  end
endmodule
